// File: rtl/cam_pkg.sv
// Shared sizing constants and types for the CAM entry allocator.
package cam_pkg;

  localparam int CAM_DATA  = 32;
  localparam int CAM_DEPTH = 32;

  // Address width for a given entry count, never narrower than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CAM_ADDR = addr_bits(CAM_DEPTH);

  typedef logic [CAM_ADDR-1:0] cam_addr_t;
  typedef logic [CAM_DATA-1:0] cam_data_t;

endpackage

// File: rtl/cam_alloc_sel.sv
// Free-slot selector: scans the free vector from a start entry (wrapping) and
// returns the first WRITE free entries in search order plus per-slot valid flags.
module cam_alloc_sel
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int WRITE = 4,
  parameter int ADDR  = addr_bits(DEPTH)
) (
  input  logic [DEPTH-1:0]           free_vec,
  input  logic [ADDR-1:0]            start,
  output logic [WRITE-1:0][ADDR-1:0] addr,
  output logic [WRITE-1:0]           vld
);

  always_comb begin
    int n;
    int idx;
    logic [ADDR-1:0] sel;
    addr = '0;
    vld  = '0;
    n    = 0;
    idx  = 0;
    sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(start) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      sel = ADDR'(idx);
      if (free_vec[sel] && (n < WRITE)) begin
        // slot n is the n-th free entry met in search order
        for (int w = 0; w < WRITE; w++) begin
          if (n == w) begin
            addr[w] = sel;
            vld[w]  = 1'b1;
          end
        end
        n = n + 1;
      end
    end
  end

endmodule

// File: rtl/cam_alloc.sv
// CAM entry allocator: grants inserts to free entries, retires freed entries,
// drives the registered CAM write port. CAM_ALLOC_ROUNDROBIN_EN enables rotating search.
module cam_alloc
  import cam_pkg::*;
#(
  parameter int DATA  = CAM_DATA,
  parameter int DEPTH = CAM_DEPTH,
  parameter int WRITE = 4,
  parameter int FREE  = 2,
  parameter int ADDR  = addr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WRITE-1:0]      ins_,
  input  logic [WRITE*DATA-1:0] ins_mask,
  input  logic [WRITE*DATA-1:0] ins_data,
  output logic [WRITE-1:0]      ins_ack,
  output logic [WRITE*ADDR-1:0] ins_addr,
  input  logic [FREE-1:0]       free_,
  input  logic [FREE*ADDR-1:0]  free_addr,
  output logic [WRITE-1:0]      we_,
  output logic [WRITE*DATA-1:0] wm,
  output logic [WRITE*DATA-1:0] wd,
  output logic [WRITE*ADDR-1:0] waddr,
  output logic                  full,
  output logic [ADDR:0]         count
);

  logic [DEPTH-1:0]           valid, set_vec, clr_vec;
  logic [ADDR-1:0]            start;
  logic [WRITE-1:0][ADDR-1:0] sel_addr;
  logic [WRITE-1:0]           sel_vld, grant;
  logic [WRITE*ADDR-1:0]      gaddr;
  logic [ADDR:0]              n_grant, n_free, count_next;

  cam_alloc_sel #(.DEPTH(DEPTH), .WRITE(WRITE), .ADDR(ADDR)) u_sel (
    .free_vec (~valid),
    .start    (start),
    .addr     (sel_addr),
    .vld      (sel_vld)
  );

  // The r-th requesting port (ascending index) takes selector slot r.
  always_comb begin
    int r;
    r       = 0;
    grant   = '0;
    gaddr   = '0;
    set_vec = '0;
    n_grant = '0;
    for (int k = 0; k < WRITE; k++) begin
      if (!ins_[k]) begin
        for (int w = 0; w < WRITE; w++) begin
          if ((r == w) && sel_vld[w]) begin
            grant[k]                = 1'b1;
            gaddr[k*ADDR +: ADDR]   = sel_addr[w];
            set_vec[sel_addr[w]]    = 1'b1;
            n_grant                 = n_grant + (ADDR+1)'(1);
          end
        end
        r = r + 1;
      end
    end
  end

  // Only currently valid entries retire; duplicates collapse onto one bit.
  always_comb begin
    clr_vec = '0;
    n_free  = '0;
    for (int f = 0; f < FREE; f++) begin
      if (!free_[f])
        clr_vec[free_addr[f*ADDR +: ADDR]] = valid[free_addr[f*ADDR +: ADDR]];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_vec[i]) n_free = n_free + (ADDR+1)'(1);
    end
  end

  assign count_next = count + n_grant - n_free;
  assign ins_ack    = grant & {WRITE{reset}};
  assign ins_addr   = gaddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      count <= '0;
      full  <= 1'b0;
      we_   <= '1;
      wm    <= '0;
      wd    <= '0;
      waddr <= '0;
    end else begin
      valid <= (valid & ~clr_vec) | set_vec;
      count <= count_next;
      full  <= (count_next == (ADDR+1)'(DEPTH));
      waddr <= gaddr;
      for (int k = 0; k < WRITE; k++) begin
        we_[k]              <= ~grant[k];
        wm[k*DATA +: DATA]  <= grant[k] ? ins_mask[k*DATA +: DATA] : '0;
        wd[k*DATA +: DATA]  <= grant[k] ? ins_data[k*DATA +: DATA] : '0;
      end
    end
  end

`ifdef CAM_ALLOC_ROUNDROBIN_EN
  logic [ADDR-1:0] ptr, last;

  // Highest granted port holds the last entry handed out this cycle.
  always_comb begin
    last = '0;
    for (int k = 0; k < WRITE; k++) begin
      if (grant[k]) last = gaddr[k*ADDR +: ADDR];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (|grant)
      ptr <= (int'(last) == DEPTH-1) ? '0 : last + ADDR'(1);
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc: directed scenarios plus randomized traffic
// checked against an entry-list reference model.
module tb_cam_alloc;

  localparam int DATA  = 32;
  localparam int DEPTH = 32;
  localparam int WRITE = 4;
  localparam int FREE  = 2;
  localparam int ADDR  = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [WRITE-1:0]      ins_ = '1;
  logic [WRITE*DATA-1:0] ins_mask = '0;
  logic [WRITE*DATA-1:0] ins_data = '0;
  logic [WRITE-1:0]      ins_ack;
  logic [WRITE*ADDR-1:0] ins_addr;
  logic [FREE-1:0]       free_ = '1;
  logic [FREE*ADDR-1:0]  free_addr = '0;
  logic [WRITE-1:0]      we_;
  logic [WRITE*DATA-1:0] wm;
  logic [WRITE*DATA-1:0] wd;
  logic [WRITE*ADDR-1:0] waddr;
  logic                  full;
  logic [ADDR:0]         count;

  int n_cmp = 0;
  int n_err = 0;

  cam_alloc #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE), .FREE(FREE)) dut (
    .clk(clk), .reset(reset), .ins_(ins_), .ins_mask(ins_mask), .ins_data(ins_data),
    .ins_ack(ins_ack), .ins_addr(ins_addr), .free_(free_), .free_addr(free_addr),
    .we_(we_), .wm(wm), .wd(wd), .waddr(waddr), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy as a plain bit array, search order as an entry list.
  bit                    mv [DEPTH];
  int                    mptr;
  logic [WRITE-1:0]      e_ack;
  logic [WRITE*ADDR-1:0] e_addr;
  logic [WRITE-1:0]      e_we;
  logic [WRITE*DATA-1:0] e_wm, e_wd;
  logic [WRITE*ADDR-1:0] e_waddr;
  int                    e_count;
  logic                  e_full;

  task automatic model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    mptr = 0; e_ack = '0; e_addr = '0; e_we = '1;
    e_wm = '0; e_wd = '0; e_waddr = '0; e_count = 0; e_full = 1'b0;
  endtask

  task automatic model_eval();
    int list[$];
    int r;
    e_ack = '0; e_addr = '0; r = 0;
    for (int i = 0; i < DEPTH; i++)
      if (!mv[(mptr + i) % DEPTH]) list.push_back((mptr + i) % DEPTH);
    for (int k = 0; k < WRITE; k++) begin
      if (!ins_[k]) begin
        if (r < list.size()) begin
          e_ack[k] = 1'b1;
          e_addr[k*ADDR +: ADDR] = ADDR'(list[r]);
        end
        r++;
      end
    end
  endtask

  task automatic model_commit();
    bit gone [DEPTH];
    int a;
    int last;
    foreach (gone[i]) gone[i] = 1'b0;
    for (int f = 0; f < FREE; f++) begin
      a = int'(free_addr[f*ADDR +: ADDR]);
      if (!free_[f] && mv[a]) gone[a] = 1'b1;
    end
    e_we = '1; e_wm = '0; e_wd = '0; e_waddr = '0; last = -1;
    for (int k = 0; k < WRITE; k++) begin
      if (e_ack[k]) begin
        a = int'(e_addr[k*ADDR +: ADDR]);
        mv[a] = 1'b1;
        e_we[k] = 1'b0;
        e_wm[k*DATA +: DATA] = ins_mask[k*DATA +: DATA];
        e_wd[k*DATA +: DATA] = ins_data[k*DATA +: DATA];
        e_waddr[k*ADDR +: ADDR] = ADDR'(a);
        last = a;
      end
    end
    foreach (gone[i]) if (gone[i]) mv[i] = 1'b0;
    e_count = 0;
    foreach (mv[i]) if (mv[i]) e_count++;
    e_full = (e_count == DEPTH);
`ifdef CAM_ALLOC_ROUNDROBIN_EN
    if (last >= 0) mptr = (last + 1) % DEPTH;
`endif
  endtask

  task automatic do_reset();
    ins_ = '1; free_ = '1; free_addr = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [WRITE*ADDR-1:0] exp_addr;
    exp_addr = {5'd3, 5'd2, 5'd1, 5'd0};
    ins_ = 4'b0000;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ins_ack); end
    n_cmp++; if (we_ !== 4'b1111) begin n_err++; $display("FAIL reset_we got=%b exp=1111", we_); end
    n_cmp++; if (count !== 6'd0 || full !== 1'b0) begin n_err++; $display("FAIL reset_count got=%0d/%b exp=0/0", count, full); end
    @(posedge clk); #1;
    n_cmp++; if (we_ !== 4'b1111) begin n_err++; $display("FAIL reset_hold_we got=%b exp=1111", we_); end
    reset = 1'b1;
    #1;
    n_cmp++; if (ins_ack !== 4'b1111) begin n_err++; $display("FAIL first_ack got=%b exp=1111", ins_ack); end
    n_cmp++; if (ins_addr !== exp_addr) begin n_err++; $display("FAIL first_addr got=%h exp=%h", ins_addr, exp_addr); end
    @(posedge clk); #1;
    ins_ = '1;
    n_cmp++; if (we_ !== 4'b0000) begin n_err++; $display("FAIL first_we got=%b exp=0000", we_); end
    n_cmp++; if (waddr !== exp_addr) begin n_err++; $display("FAIL first_waddr got=%h exp=%h", waddr, exp_addr); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 6'd4 || full !== 1'b0) begin n_err++; $display("FAIL first_count got=%0d/%b exp=4/0", count, full); end
    n_cmp++; if (we_ !== 4'b1111) begin n_err++; $display("FAIL idle_we got=%b exp=1111", we_); end
  endtask

  task automatic test_fill();
    do_reset();
    ins_ = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (ins_ack !== 4'b1111) begin n_err++; $display("FAIL fill_ack cyc=%0d got=%b exp=1111", c, ins_ack); end
      @(posedge clk); #1;
    end
    n_cmp++; if (count !== 6'd32 || full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%0d/%b exp=32/1", count, full); end
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0000) begin n_err++; $display("FAIL full_ack got=%b exp=0000", ins_ack); end
    @(posedge clk); #1;
    n_cmp++; if (we_ !== 4'b1111 || count !== 6'd32) begin n_err++; $display("FAIL full_we got=%b/%0d exp=1111/32", we_, count); end
  endtask

  task automatic test_full_free();
    free_ = 2'b00; free_addr = {5'd5, 5'd5}; ins_ = 4'b0000;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0000) begin n_err++; $display("FAIL dupfree_ack got=%b exp=0000", ins_ack); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 6'd31 || full !== 1'b0) begin n_err++; $display("FAIL dupfree_count got=%0d/%b exp=31/0", count, full); end
    free_ = 2'b11;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0001 || ins_addr[ADDR-1:0] !== 5'd5) begin n_err++; $display("FAIL refill_ack got=%b/%0d exp=0001/5", ins_ack, ins_addr[ADDR-1:0]); end
    @(posedge clk); #1;
    n_cmp++; if (we_ !== 4'b1110 || waddr[ADDR-1:0] !== 5'd5 || count !== 6'd32 || full !== 1'b1) begin
      n_err++; $display("FAIL refill_write got=%b/%0d/%0d/%b exp=1110/5/32/1", we_, waddr[ADDR-1:0], count, full);
    end
  endtask

  task automatic test_partial();
    ins_ = '1; free_ = 2'b00; free_addr = {5'd20, 5'd9};
    @(posedge clk); #1;
    n_cmp++; if (count !== 6'd30) begin n_err++; $display("FAIL partial_count got=%0d exp=30", count); end
    free_ = 2'b11; ins_ = 4'b0000;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0011) begin n_err++; $display("FAIL partial_ack got=%b exp=0011", ins_ack); end
    n_cmp++; if (ins_addr[2*ADDR-1:0] !== {5'd20, 5'd9}) begin n_err++; $display("FAIL partial_addr got=%h exp=%h", ins_addr[2*ADDR-1:0], {5'd20, 5'd9}); end
    @(posedge clk); #1;
    ins_ = '1;
    n_cmp++; if (we_ !== 4'b1100 || count !== 6'd32 || full !== 1'b1) begin n_err++; $display("FAIL partial_write got=%b/%0d/%b exp=1100/32/1", we_, count, full); end
  endtask

  task automatic test_free_invalid();
    do_reset();
    free_ = 2'b00; free_addr = {5'd30, 5'd30};
    @(posedge clk); #1;
    n_cmp++; if (count !== 6'd0 || full !== 1'b0) begin n_err++; $display("FAIL freeinv_count got=%0d/%b exp=0/0", count, full); end
    free_ = 2'b11; ins_ = 4'b1110;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0001 || ins_addr[ADDR-1:0] !== 5'd0) begin n_err++; $display("FAIL freeinv_ack got=%b/%0d exp=0001/0", ins_ack, ins_addr[ADDR-1:0]); end
    @(posedge clk); #1;
    ins_ = '1;
    n_cmp++; if (count !== 6'd1) begin n_err++; $display("FAIL freeinv_after got=%0d exp=1", count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ins_ = 4'b0000;
    @(posedge clk); #1;
    n_cmp++; if (we_ !== 4'b0000) begin n_err++; $display("FAIL mid_pre_we got=%b exp=0000", we_); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (we_ !== 4'b1111 || count !== 6'd0 || full !== 1'b0 || ins_ack !== 4'b0000) begin
      n_err++; $display("FAIL mid_async got=%b/%0d/%b/%b exp=1111/0/0/0000", we_, count, full, ins_ack);
    end
    @(posedge clk); #1;
    n_cmp++; if (we_ !== 4'b1111 || count !== 6'd0) begin n_err++; $display("FAIL mid_hold got=%b/%0d exp=1111/0", we_, count); end
    ins_ = '1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef CAM_ALLOC_ROUNDROBIN_EN
  task automatic test_rr();
    do_reset();
    ins_ = 4'b0000;
    @(posedge clk); #1;
    ins_ = '1; free_ = 2'b00; free_addr = {5'd1, 5'd0};
    @(posedge clk); #1;
    free_ = 2'b11; ins_ = 4'b1110;
    @(negedge clk);
    n_cmp++; if (ins_ack !== 4'b0001 || ins_addr[ADDR-1:0] !== 5'd4) begin n_err++; $display("FAIL rr_addr got=%b/%0d exp=0001/4", ins_ack, ins_addr[ADDR-1:0]); end
    @(posedge clk); #1;
    ins_ = '1;
  endtask
`endif

  task automatic test_random();
    logic [WRITE*ADDR-1:0] amask;
    bit fill_phase;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      fill_phase = ((c / 100) % 2) == 0;
      ins_ = fill_phase ? 4'($urandom & $urandom) : 4'($urandom | $urandom);
      free_ = fill_phase ? 2'($urandom | $urandom | $urandom) : 2'($urandom & $urandom);
      free_addr[ADDR-1:0] = 5'($urandom_range(0, DEPTH-1));
      free_addr[2*ADDR-1:ADDR] = ($urandom_range(0, 5) == 0) ? free_addr[ADDR-1:0] : 5'($urandom_range(0, DEPTH-1));
      ins_mask = {$urandom, $urandom, $urandom, $urandom};
      ins_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      model_eval();
      amask = '0;
      for (int k = 0; k < WRITE; k++) if (e_ack[k]) amask[k*ADDR +: ADDR] = '1;
      n_cmp++; if (ins_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, ins_ack, e_ack); end
      n_cmp++; if ((ins_addr & amask) !== (e_addr & amask)) begin n_err++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, ins_addr & amask, e_addr & amask); end
      @(posedge clk); #1;
      model_commit();
      n_cmp++; if (we_ !== e_we) begin n_err++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, we_, e_we); end
      n_cmp++; if (waddr !== e_waddr) begin n_err++; $display("FAIL rnd_waddr cyc=%0d got=%h exp=%h", c, waddr, e_waddr); end
      n_cmp++; if (wm !== e_wm || wd !== e_wd) begin n_err++; $display("FAIL rnd_wmwd cyc=%0d got=%h/%h exp=%h/%h", c, wm, wd, e_wm, e_wd); end
      n_cmp++; if (count !== 6'(e_count)) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, e_count); end
      n_cmp++; if (full !== e_full) begin n_err++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", c, full, e_full); end
    end
    ins_ = '1; free_ = '1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_free();
    test_partial();
    test_free_invalid();
    test_reset_mid();
`ifdef CAM_ALLOC_ROUNDROBIN_EN
    test_rr();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
